// File: rtl/sram_tiled_1r1w.sv
// Simple-dual-port memory tiled from sky130 32x512 macros: byte-masked
// writes, write-first collision forwarding, range checking, 1- or 2-cycle
// read latency and per-bank chip-select gating.

// Behavioural stand-in for the sky130 1rw1r macro. Port 0 is used as a
// write port only; port 1 is read-only. Reads see pre-write contents when
// both ports hit the same row on the same edge.
module sky130_sram_2kbyte_1rw1r_32x512_8 (
    input  logic        clk0,
    input  logic        csb0,
    input  logic        web0,
    input  logic [3:0]  wmask0,
    input  logic [8:0]  addr0,
    input  logic [31:0] din0,
    output logic [31:0] dout0,
    input  logic        clk1,
    input  logic        csb1,
    input  logic [8:0]  addr1,
    output logic [31:0] dout1
);
    logic [31:0] mem [0:511];

    // Port 0: byte-masked write, or read when web0 is high.
    always_ff @(posedge clk0) begin
        if (!csb0) begin
            if (!web0) begin
                for (int i = 0; i < 4; i++)
                    if (wmask0[i]) mem[addr0][8*i +: 8] <= din0[8*i +: 8];
            end else begin
                dout0 <= mem[addr0];
            end
        end
    end

    // Port 1: registered read.
    always_ff @(posedge clk1) begin
        if (!csb1) dout1 <= mem[addr1];
    end
endmodule

module sram_tiled_1r1w #(
    parameter int DATA_W   = 64,
    parameter int DEPTH    = 1024,
    parameter int READ_LAT = 1,
    parameter int ADDR_W   = $clog2(DEPTH)
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                w_en,
    input  logic [ADDR_W-1:0]   w_addr,
    input  logic [DATA_W-1:0]   w_data,
    input  logic [DATA_W/8-1:0] w_mask,
    input  logic                r_en,
    input  logic [ADDR_W-1:0]   r_addr,
    output logic [DATA_W-1:0]   r_data,
    output logic                r_valid,
    output logic                r_err,
    output logic                w_err
);
    localparam int NCOL   = (DATA_W + 31) / 32;
    localparam int NBANK  = DEPTH / 512;
    localparam int PAD_W  = NCOL * 32;
    localparam int NBYTE  = DATA_W / 8;
    localparam int BANK_W = (ADDR_W > 9) ? ADDR_W - 9 : 1;

    logic                  w_inr, r_inr, w_ok, r_ok, coll;
    logic [BANK_W-1:0]     w_bank, r_bank;
    logic [NBANK-1:0]      csb0_w, csb1_w;
    logic [PAD_W-1:0]      wdata_pad;
    logic [NCOL*4-1:0]     wmask_pad;
    logic [NBANK-1:0][PAD_W-1:0] dout1_w, dout0_unused;

    logic                  v1_q, err1_q, coll1_q, w_err_q;
    logic [BANK_W-1:0]     bank1_q;
    logic [DATA_W-1:0]     cdata_q;
    logic [NBYTE-1:0]      cmask_q;
    logic [DATA_W-1:0]     rd_mux, rdata_d;

    assign w_bank = BANK_W'(w_addr >> 9);
    assign r_bank = BANK_W'(r_addr >> 9);
    assign w_inr  = ({1'b0, w_addr} < (ADDR_W+1)'(DEPTH));
    assign r_inr  = ({1'b0, r_addr} < (ADDR_W+1)'(DEPTH));
    assign w_ok   = w_en && w_inr && reset_n;
    assign r_ok   = r_en && r_inr && reset_n;
    assign coll   = w_ok && r_ok && (w_addr == r_addr);
    assign w_err  = w_err_q;

    // Pad write data/mask out to whole macro columns; padding never writes.
    always_comb begin
        wdata_pad = '0;
        wmask_pad = '0;
        wdata_pad[DATA_W-1:0] = w_data;
        wmask_pad[NBYTE-1:0]  = w_mask;
    end

    // Chip selects: at most one bank active per port, none when out of range.
    always_comb begin
        for (int b = 0; b < NBANK; b++) begin
            csb0_w[b] = !(w_ok && (w_bank == BANK_W'(b)));
            csb1_w[b] = !(r_ok && (r_bank == BANK_W'(b)));
        end
    end

    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        for (genvar c = 0; c < NCOL; c++) begin : g_col
            sky130_sram_2kbyte_1rw1r_32x512_8 u_macro (
                .clk0   (clock),
                .csb0   (csb0_w[b]),
                .web0   (csb0_w[b]),
                .wmask0 (wmask_pad[4*c +: 4]),
                .addr0  (w_addr[8:0]),
                .din0   (wdata_pad[32*c +: 32]),
                .dout0  (dout0_unused[b][32*c +: 32]),
                .clk1   (clock),
                .csb1   (csb1_w[b]),
                .addr1  (r_addr[8:0]),
                .dout1  (dout1_w[b][32*c +: 32])
            );
        end
    end

    // Request stage: bank select, range flag and collision write data.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            v1_q    <= 1'b0;
            err1_q  <= 1'b0;
            bank1_q <= '0;
            coll1_q <= 1'b0;
            cdata_q <= '0;
            cmask_q <= '0;
            w_err_q <= 1'b0;
        end else begin
            v1_q    <= r_en;
            err1_q  <= r_en && !r_inr;
            bank1_q <= r_bank;
            coll1_q <= coll;
            w_err_q <= w_en && !w_inr;
            if (coll) begin
                cdata_q <= w_data;
                cmask_q <= w_mask;
            end
        end
    end

    // Bank mux, then overlay bytes written in the same cycle as the read.
    always_comb begin
        rd_mux = '0;
        for (int b = 0; b < NBANK; b++)
            if (!err1_q && bank1_q == BANK_W'(b)) rd_mux = dout1_w[b][DATA_W-1:0];
        rdata_d = rd_mux;
        for (int i = 0; i < NBYTE; i++)
            if (coll1_q && cmask_q[i]) rdata_d[8*i +: 8] = cdata_q[8*i +: 8];
    end

    if (READ_LAT == 2) begin : g_lat2
        logic              v2_q, err2_q;
        logic [DATA_W-1:0] rdata_q;

        // Output register; data holds between valid pulses.
        always_ff @(posedge clock) begin
            if (!reset_n) begin
                v2_q    <= 1'b0;
                err2_q  <= 1'b0;
                rdata_q <= '0;
            end else begin
                v2_q   <= v1_q;
                err2_q <= err1_q;
                if (v1_q) rdata_q <= rdata_d;
            end
        end

        assign r_valid = v2_q && reset_n;
        assign r_err   = err2_q && reset_n;
        assign r_data  = rdata_q;
    end else begin : g_lat1
        assign r_valid = v1_q && reset_n;
        assign r_err   = err1_q && reset_n;
        assign r_data  = r_valid ? rdata_d : '0;
    end
endmodule
